axis_header_prepend_v2: RTL and testbench



---
 rtl/axis_header_prepend_v2_if.sv | 17 +
 rtl/axis_header_prepend_v2.sv | 151 +++++++++++++++
 tb/tb_axis_header_prepend_v2.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_header_prepend_v2_if.sv
// AXI-Stream bundle used on both sides of the header inserter.
interface axis_header_prepend_v2_if #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 2
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tready;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_header_prepend_v2.sv
// Prepends a HDR_BYTES-byte header to every AXI-Stream packet with full backpressure.
// Define HDR_PREPEND_STATS_EN to enable the pkt_count/byte_count statistics counters.
module axis_header_prepend_v2 #(
    parameter int DATA_WIDTH = 512,
    parameter int HDR_BYTES  = 14,
    parameter int USER_WIDTH = 2
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_areset,
    input  logic                   hdr_valid,
    input  logic [8*HDR_BYTES-1:0] hdr_data,
    output logic                   hdr_ready,
    axis_header_prepend_v2_if.slave  s00_axis,
    axis_header_prepend_v2_if.master m00_axis,
    output logic [31:0]            pkt_count,
    output logic [47:0]            byte_count
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int HDR_W      = 8 * HDR_BYTES;
    localparam int PAY_BYTES  = KEEP_WIDTH - HDR_BYTES;
    localparam int PAY_W      = DATA_WIDTH - HDR_W;
    localparam int CNT_W      = $clog2(KEEP_WIDTH + 1);
    localparam logic [KEEP_WIDTH-1:0] HDR_KEEP = {{PAY_BYTES{1'b0}}, {HDR_BYTES{1'b1}}};

    typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

    function automatic logic [CNT_W-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + CNT_W'(k[i]);
        return c;
    endfunction

    // Zero every byte lane whose keep bit is clear.
    function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [KEEP_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_WIDTH; i++)
            if (k[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    state_t                state;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [KEEP_WIDTH-1:0] keep_p1;
    logic                  last_p1;
    logic [USER_WIDTH-1:0] user_p1;
    logic [HDR_W-1:0]      carry_p1;
    logic [KEEP_WIDTH-1:0] tail_keep_p1;
    logic [USER_WIDTH-1:0] tail_user_p1;

    logic                  out_free;
    logic                  s_ready;
    logic                  accept;
    logic                  in_fits;
    logic [HDR_W-1:0]      carry_sel;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [KEEP_WIDTH-1:0] fit_keep;

    // Stage 0: input acceptance and beat assembly
    always_comb begin
        out_free = !vld_p1 || m00_axis.tready;
        s_ready  = 1'b0;
        unique case (state)
            IDLE:    s_ready = out_free && hdr_valid;
            STREAM:  s_ready = out_free;
            default: s_ready = 1'b0;
        endcase
        if (s00_axis_areset) s_ready = 1'b0;
        accept    = s00_axis.tvalid && s_ready;
        hdr_ready = accept && (state == IDLE);
        carry_sel = (state == IDLE) ? hdr_data : carry_p1;
        beat_data = {s00_axis.tdata[PAY_W-1:0], carry_sel};
        in_fits   = popcnt(s00_axis.tkeep) <= CNT_W'(PAY_BYTES);
        fit_keep  = (s00_axis.tkeep << HDR_BYTES) | HDR_KEEP;
    end

    assign s00_axis.tready = s_ready;

    // Stage 1: output register and framing FSM
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state        <= IDLE;
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            keep_p1      <= '0;
            last_p1      <= 1'b0;
            user_p1      <= '0;
            carry_p1     <= '0;
            tail_keep_p1 <= '0;
            tail_user_p1 <= '0;
        end else if (out_free) begin
            vld_p1 <= 1'b0;
            if (state == TAIL) begin
                vld_p1  <= 1'b1;
                data_p1 <= mask_bytes({{PAY_W{1'b0}}, carry_p1}, tail_keep_p1);
                keep_p1 <= tail_keep_p1;
                last_p1 <= 1'b1;
                user_p1 <= tail_user_p1;
                state   <= IDLE;
            end else if (accept) begin
                vld_p1   <= 1'b1;
                user_p1  <= s00_axis.tuser;
                carry_p1 <= s00_axis.tdata[DATA_WIDTH-1 -: HDR_W];
                if (!s00_axis.tlast) begin
                    data_p1 <= beat_data;
                    keep_p1 <= '1;
                    last_p1 <= 1'b0;
                    state   <= STREAM;
                end else if (in_fits) begin
                    data_p1 <= mask_bytes(beat_data, fit_keep);
                    keep_p1 <= fit_keep;
                    last_p1 <= 1'b1;
                    state   <= IDLE;
                end else begin
                    // Last beat overflows: emit it full and flush the carried bytes next.
                    data_p1      <= beat_data;
                    keep_p1      <= '1;
                    last_p1      <= 1'b0;
                    tail_keep_p1 <= s00_axis.tkeep >> PAY_BYTES;
                    tail_user_p1 <= s00_axis.tuser;
                    state        <= TAIL;
                end
            end
        end
    end

    assign m00_axis.tvalid = vld_p1;
    assign m00_axis.tdata  = data_p1;
    assign m00_axis.tkeep  = keep_p1;
    assign m00_axis.tlast  = last_p1;
    assign m00_axis.tuser  = user_p1;

`ifdef HDR_PREPEND_STATS_EN
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else if (vld_p1 && m00_axis.tready) begin
            byte_count <= byte_count + 48'(popcnt(keep_p1));
            if (last_p1) pkt_count <= pkt_count + 32'd1;
        end
    end
`else
    assign pkt_count  = '0;
    assign byte_count = '0;
`endif

endmodule

// File: tb/tb_axis_header_prepend_v2.sv
// Bench for axis_header_prepend_v2: directed and random packets against a byte-level frame model.
module tb_axis_header_prepend_v2;
    localparam int DW = 128;
    localparam int KW = 16;
    localparam int HB = 14;
    localparam int UW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
        int            cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          hdr_valid;
    logic [8*HB-1:0] hdr_data;
    logic          hdr_ready;
    logic [31:0]   pkt_count;
    logic [47:0]   byte_count;

    axis_header_prepend_v2_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
    axis_header_prepend_v2_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

    axis_header_prepend_v2 #(.DATA_WIDTH(DW), .HDR_BYTES(HB), .USER_WIDTH(UW)) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .hdr_valid      (hdr_valid),
        .hdr_data       (hdr_data),
        .hdr_ready      (hdr_ready),
        .s00_axis       (s_if),
        .m00_axis       (m_if),
        .pkt_count      (pkt_count),
        .byte_count     (byte_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = held low, 1 = always, 2 = 1,0,0 pattern, 3 = random
    int rdy_mode = 0;
    int rdy_ph = 0;
    always @(posedge clk) begin
        #1;
        rdy_ph++;
        case (rdy_mode)
            0:       m_if.tready = 1'b0;
            1:       m_if.tready = 1'b1;
            2:       m_if.tready = (rdy_ph % 3 == 1);
            default: m_if.tready = 1'($urandom_range(1, 0));
        endcase
    end

    beat_t obs_q[$];
    beat_t exp_q[$];
    int    cyc = 0;
    int    hdr_pulses = 0;
    int    stall_viol = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_b;

    always @(negedge clk) begin
        beat_t b;
        cyc++;
        b.data = m_if.tdata;
        b.keep = m_if.tkeep;
        b.last = m_if.tlast;
        b.user = m_if.tuser;
        b.cyc  = cyc;
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) obs_q.push_back(b);
        if (hdr_ready === 1'b1) hdr_pulses++;
        if (!rst && prev_stall &&
            (m_if.tvalid !== 1'b1 || b.data !== prev_b.data || b.keep !== prev_b.keep ||
             b.last !== prev_b.last || b.user !== prev_b.user))
            stall_viol++;
        prev_stall = !rst && m_if.tvalid === 1'b1 && m_if.tready !== 1'b1;
        prev_b = b;
    end

    logic [8*HB-1:0] cur_hdr;
    byte unsigned    pay_q[$];
    logic [UW-1:0]   usr_q[$];
    int              exp_pkts = 0;
    longint          exp_bytes = 0;

    function automatic logic [127:0] exp_pkt_cnt();
`ifdef HDR_PREPEND_STATS_EN
        return 128'(exp_pkts);
`else
        return 128'(0);
`endif
    endfunction

    function automatic logic [127:0] exp_byte_cnt();
`ifdef HDR_PREPEND_STATS_EN
        return 128'(exp_bytes);
`else
        return 128'(0);
`endif
    endfunction

    task automatic make_pkt(input int len);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        cur_hdr = r[8*HB-1:0];
        pay_q.delete();
        usr_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
        for (int i = 0; i < (len + KW - 1) / KW; i++) usr_q.push_back(UW'($urandom));
    endtask

    // Reference: the wire frame is header bytes then payload bytes, cut into KW-byte beats.
    task automatic build_exp();
        byte unsigned fb[$];
        beat_t e;
        int nout;
        int idx;
        for (int i = 0; i < HB; i++) fb.push_back(cur_hdr[8*i +: 8]);
        foreach (pay_q[i]) fb.push_back(pay_q[i]);
        nout = (fb.size() + KW - 1) / KW;
        for (int j = 0; j < nout; j++) begin
            e.data = '0;
            e.keep = '0;
            for (int b = 0; b < KW; b++) begin
                idx = j * KW + b;
                if (idx < fb.size()) begin
                    e.data[8*b +: 8] = fb[idx];
                    e.keep[b] = 1'b1;
                    exp_bytes++;
                end
            end
            e.last = (j == nout - 1);
            e.user = usr_q[(j < usr_q.size()) ? j : usr_q.size() - 1];
            e.cyc  = 0;
            if (e.last) exp_pkts++;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_packet(input int max_gap, input int stop_after);
        int nb;
        int g;
        int idx;
        bit accepted;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        nb = usr_q.size();
        for (int i = 0; i < nb && i != stop_after; i++) begin
            if (max_gap > 0) begin
                g = $urandom_range(max_gap, 0);
                s_if.tvalid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            k = '0;
            for (int b = 0; b < KW; b++) begin
                idx = i * KW + b;
                if (idx < pay_q.size()) begin
                    d[8*b +: 8] = pay_q[idx];
                    k[b] = 1'b1;
                end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tkeep  = k;
            s_if.tlast  = (i == nb - 1);
            s_if.tuser  = usr_q[i];
            hdr_valid   = 1'b1;
            hdr_data    = cur_hdr;
            accepted = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (s_if.tready === 1'b1) begin
                    accepted = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!accepted) begin
                check("accept_timeout", 128'(0), 128'(1));
                s_if.tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic expect_all(input string tag);
        beat_t o;
        beat_t e;
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_beats"}, 128'(obs_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_tdata"}, 128'(o.data), 128'(e.data));
            check({tag, "_tkeep"}, 128'(o.keep), 128'(e.keep));
            check({tag, "_tlast"}, 128'(o.last), 128'(e.last));
            check({tag, "_tuser"}, 128'(o.user), 128'(e.user));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        int nl;
        int lens[8] = '{1, 2, 3, 16, 17, 18, 19, 32};

        s_if.tvalid = 1'b1;
        s_if.tdata  = '0;
        s_if.tkeep  = 16'h0001;
        s_if.tlast  = 1'b1;
        s_if.tuser  = '0;
        hdr_valid   = 1'b1;
        hdr_data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 128'(m_if.tvalid), 128'(0));
        check("rst_m_tdata",  128'(m_if.tdata),  128'(0));
        check("rst_m_tkeep",  128'(m_if.tkeep),  128'(0));
        check("rst_m_tlast",  128'(m_if.tlast),  128'(0));
        check("rst_m_tuser",  128'(m_if.tuser),  128'(0));
        check("rst_s_tready", 128'(s_if.tready), 128'(0));
        check("rst_hdr_ready", 128'(hdr_ready),  128'(0));
        check("rst_pkt_count", 128'(pkt_count),  128'(0));
        check("rst_byte_count", 128'(byte_count), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        rdy_mode = 1;
        repeat (2) @(posedge clk); #1;

        // Single beat that fits: 2 payload bytes
        make_pkt(2);
        build_exp();
        h0 = hdr_pulses;
        send_packet(0, -1);
        expect_all("fit1");
        check("fit1_hdr_ready", 128'(hdr_pulses - h0), 128'(1));

        // Single beat that overflows into a tail beat; input held off during the tail
        make_pkt(3);
        build_exp();
        h0 = hdr_pulses;
        send_packet(0, -1);
        s_if.tvalid = 1'b1;
        s_if.tkeep  = 16'h0001;
        s_if.tlast  = 1'b1;
        hdr_valid   = 1'b1;
        @(negedge clk);
        check("tail_s_tready", 128'(s_if.tready), 128'(0));
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        expect_all("tail1");
        check("tail1_hdr_ready", 128'(hdr_pulses - h0), 128'(1));
        check("stats_pkt_count",  128'(pkt_count),  exp_pkt_cnt());
        check("stats_byte_count", 128'(byte_count), exp_byte_cnt());

        // Three-beat packet under stalling downstream
        rdy_mode = 2;
        make_pkt(40);
        build_exp();
        send_packet(0, -1);
        expect_all("stall3");

        // Back-to-back single-beat packets with header always available
        rdy_mode = 1;
        make_pkt(2);
        build_exp();
        h0 = hdr_pulses;
        send_packet(0, -1);
        make_pkt(1);
        build_exp();
        send_packet(0, -1);
        for (int t = 0; t < 50 && obs_q.size() < 2; t++) @(negedge clk);
        #1;
        if (obs_q.size() >= 2) check("b2b_consecutive", 128'(obs_q[1].cyc - obs_q[0].cyc), 128'(1));
        else check("b2b_beats_seen", 128'(obs_q.size()), 128'(2));
        expect_all("b2b");
        check("b2b_hdr_ready", 128'(hdr_pulses - h0), 128'(2));

        // Payload offered without a header: must wait for hdr_valid
        make_pkt(5);
        build_exp();
        hdr_valid   = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tkeep  = 16'h001F;
        s_if.tlast  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("nohdr_s_tready", 128'(s_if.tready), 128'(0));
        end
        @(posedge clk); #1;
        send_packet(0, -1);
        expect_all("nohdr");

        // Reset after two beats of a five-beat packet
        make_pkt(80);
        send_packet(0, 2);
        rst = 1'b1;
        s_if.tvalid = 1'b1;
        hdr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_m_tvalid", 128'(m_if.tvalid), 128'(0));
        check("mrst_m_tdata",  128'(m_if.tdata),  128'(0));
        check("mrst_m_tkeep",  128'(m_if.tkeep),  128'(0));
        check("mrst_m_tlast",  128'(m_if.tlast),  128'(0));
        check("mrst_s_tready", 128'(s_if.tready), 128'(0));
        nl = 0;
        foreach (obs_q[i]) if (obs_q[i].last) nl++;
        check("mrst_no_tlast", 128'(nl), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        exp_pkts = 0;
        exp_bytes = 0;
        obs_q.delete();
        repeat (3) @(negedge clk);
        check("mrst_quiet", 128'(obs_q.size()), 128'(0));
        @(posedge clk); #1;
        make_pkt(10);
        build_exp();
        h0 = hdr_pulses;
        send_packet(0, -1);
        expect_all("post_rst");
        check("post_rst_hdr_ready", 128'(hdr_pulses - h0), 128'(1));

        // Keep-boundary lengths, then random lengths with random gaps and ready
        rdy_mode = 3;
        foreach (lens[i]) begin
            make_pkt(lens[i]);
            build_exp();
            send_packet(1, -1);
            expect_all("edge");
        end
        for (int p = 0; p < 16; p++) begin
            make_pkt($urandom_range(60, 1));
            build_exp();
            h0 = hdr_pulses;
            send_packet(2, -1);
            expect_all("rand");
            check("rand_hdr_ready", 128'(hdr_pulses - h0), 128'(1));
        end

        check("stall_stability", 128'(stall_viol), 128'(0));
        check("final_pkt_count",  128'(pkt_count),  exp_pkt_cnt());
        check("final_byte_count", 128'(byte_count), exp_byte_cnt());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
